// File: rtl/rstseq_pkg.sv
// Shared types and helpers for the reset sequencer / run watchdog.
package rstseq_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_STOP  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_DONE    = 2'd1,
    CAUSE_HANG    = 2'd2,
    CAUSE_TIMEOUT = 2'd3
  } cause_e;

  // Phase count at which the highest-index channel leaves reset; the FSM
  // enters RUN on that same edge.
  function automatic int lastRelease(input int resetCycles, input int stagger,
                                     input int nCh);
    return resetCycles + (nCh - 1) * stagger;
  endfunction

endpackage

// File: rtl/rstseq_idle_cnt.sv
// Kick-clearable idle counter for hang detection. A limit of 0 disables it.
module rstseq_idle_cnt
  import rstseq_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int IDLE_LIMIT = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic kick_i,
  output logic hit_o
);

  logic [CNT_W-1:0] idleCnt_q;
  logic [CNT_W-1:0] idleCnt_d;
  logic [CNT_W-1:0] idleNext;

  assign idleNext = idleCnt_q + CNT_W'(1);

  // Count only while running; a heartbeat restarts the idle window.
  always_comb begin
    idleCnt_d = idleCnt_q;
    if (run_i) begin
      idleCnt_d = kick_i ? '0 : idleNext;
    end
  end

  // Idle counter register, cleared by the master reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idleCnt_q <= '0;
    end else begin
      idleCnt_q <= idleCnt_d;
    end
  end

  generate
    if (IDLE_LIMIT == 0) begin : g_hangOff
      assign hit_o = 1'b0;
    end else begin : g_hangOn
      assign hit_o = run_i && !kick_i && (idleNext == CNT_W'(IDLE_LIMIT));
    end
  endgenerate

endmodule

// File: rtl/rstseq_wdog.sv
// Staggered reset sequencer plus run watchdog (done / hang / timeout).
// Optional feature macro: SIM_FINISH_EN -- reports the stop cause and ends
// the simulation one edge after STOP entry; without it the block is plain
// synthesizable logic that parks in STOP until rst.
module rstseq_wdog
  import rstseq_pkg::*;
#(
  parameter int N_CH         = 2,
  parameter int RESET_CYCLES = 5,
  parameter int STAGGER      = 2,
  parameter int TIMEOUT      = 100000,
  parameter int IDLE_LIMIT   = 1024,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             kick,
  input  logic             halt_req,
  output logic [N_CH-1:0]  rst_out,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [1:0]       state,
  output logic [1:0]       cause
);

  localparam int LAST_REL = lastRelease(RESET_CYCLES, STAGGER, N_CH);

  state_e           state_q, state_d;
  cause_e           cause_q, cause_d;
  logic [CNT_W-1:0] phaseCnt_q, phaseCnt_d;
  logic [CNT_W-1:0] cycleCnt_q, cycleCnt_d;
  logic [N_CH-1:0]  rstOut_q, rstOut_d;
  logic [CNT_W-1:0] phaseNext;
  logic [CNT_W-1:0] cycleNext;
  logic             idleHit;

  assign phaseNext = phaseCnt_q + CNT_W'(1);
  assign cycleNext = cycleCnt_q + CNT_W'(1);

  rstseq_idle_cnt #(
    .CNT_W      (CNT_W),
    .IDLE_LIMIT (IDLE_LIMIT)
  ) u_idle (
    .clk_i  (clk),
    .rst_i  (rst),
    .run_i  (state_q == ST_RUN),
    .kick_i (kick),
    .hit_o  (idleHit)
  );

  // Next-state logic: staggered release, run checks in priority order, freeze on stop.
  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    phaseCnt_d = phaseCnt_q;
    cycleCnt_d = cycleCnt_q;
    rstOut_d   = rstOut_q;
    case (state_q)
      ST_RESET: begin
        phaseCnt_d = phaseNext;
        for (int i = 0; i < N_CH; i++) begin
          rstOut_d[i] = (phaseNext < CNT_W'(RESET_CYCLES + i * STAGGER));
        end
        if (phaseNext >= CNT_W'(LAST_REL)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        cycleCnt_d = cycleNext;
        if (halt_req) begin
          cause_d = CAUSE_DONE;
          state_d = ST_STOP;
        end else if (idleHit) begin
          cause_d = CAUSE_HANG;
          state_d = ST_STOP;
        end else if (cycleNext == CNT_W'(TIMEOUT)) begin
          cause_d = CAUSE_TIMEOUT;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        rstOut_d = '1;
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  // State and counter registers; master reset wins in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RESET;
      cause_q    <= CAUSE_NONE;
      phaseCnt_q <= '0;
      cycleCnt_q <= '0;
      rstOut_q   <= '1;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      phaseCnt_q <= phaseCnt_d;
      cycleCnt_q <= cycleCnt_d;
      rstOut_q   <= rstOut_d;
    end
  end

  assign rst_out   = rstOut_q;
  assign cycle_cnt = cycleCnt_q;
  assign state     = state_q;
  assign cause     = cause_q;

`ifdef SIM_FINISH_EN
  logic finishPend_q;

  initial begin
    if ((64'(TIMEOUT) >= (64'd1 << CNT_W)) || (64'(LAST_REL) >= (64'd1 << CNT_W))) begin
      $fatal(1, "rstseq_wdog: CNT_W=%0d too narrow for TIMEOUT/reset sequence", CNT_W);
    end
  end

  // Report the stop cause on STOP entry and end the simulation one edge later.
  always_ff @(posedge clk) begin
    if (rst) begin
      finishPend_q <= 1'b0;
    end else begin
      if ((state_q == ST_RUN) && (state_d == ST_STOP)) begin
        $display("rstseq_wdog: stop cause=%0d cycle_cnt=%0d", cause_d, cycleCnt_d);
        finishPend_q <= 1'b1;
      end
      if (finishPend_q) begin
        $finish;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rstseq_wdog.sv
// Self-checking bench: three differently parameterised instances share one
// stimulus stream and are compared every cycle against an edge-count model.
module tb_rstseq_wdog;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstIn, kickIn, haltIn;

  logic [1:0]  rstOut0;
  logic [3:0]  rstOut1;
  logic [2:0]  rstOut2;
  logic [31:0] cyc0, cyc1, cyc2;
  logic [1:0]  st0, st1, st2;
  logic [1:0]  ca0, ca1, ca2;

  localparam int P_N  [3] = '{2, 4, 3};
  localparam int P_R  [3] = '{5, 5, 1};
  localparam int P_S  [3] = '{2, 0, 3};
  localparam int P_TO [3] = '{50, 20, 30};
  localparam int P_IL [3] = '{8, 0, 5};

  rstseq_wdog #(.N_CH(2), .RESET_CYCLES(5), .STAGGER(2), .TIMEOUT(50),
                .IDLE_LIMIT(8), .CNT_W(32)) dut0 (
    .clk(clk), .rst(rstIn), .kick(kickIn), .halt_req(haltIn),
    .rst_out(rstOut0), .cycle_cnt(cyc0), .state(st0), .cause(ca0));

  rstseq_wdog #(.N_CH(4), .RESET_CYCLES(5), .STAGGER(0), .TIMEOUT(20),
                .IDLE_LIMIT(0), .CNT_W(32)) dut1 (
    .clk(clk), .rst(rstIn), .kick(kickIn), .halt_req(haltIn),
    .rst_out(rstOut1), .cycle_cnt(cyc1), .state(st1), .cause(ca1));

  rstseq_wdog #(.N_CH(3), .RESET_CYCLES(1), .STAGGER(3), .TIMEOUT(30),
                .IDLE_LIMIT(5), .CNT_W(32)) dut2 (
    .clk(clk), .rst(rstIn), .kick(kickIn), .halt_req(haltIn),
    .rst_out(rstOut2), .cycle_cnt(cyc2), .state(st2), .cause(ca2));

  int nComp = 0;
  int nFail = 0;
  bit mValid = 1'b0;
  // Model: edges since reset release, RUN cycles, idle run, cause, edges since stop.
  int mE [3];
  int mCyc [3];
  int mIdle [3];
  int mCause [3];
  int mAge [3];

  task automatic checkOutput(input string name, input int d,
                             input logic [31:0] act, input logic [31:0] exp);
    nComp++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s dut%0d: got %0d required %0d at %0t", name, d, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic k, input logic h);
    rstIn  = r;
    kickIn = k;
    haltIn = h;
    @(posedge clk);
    #1;
  endtask

  function automatic int lastRel(input int d);
    return P_R[d] + (P_N[d] - 1) * P_S[d];
  endfunction

  function automatic logic [31:0] expRstOut(input int d);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < P_N[d]; i++) begin
      if (mCause[d] != 0 && mAge[d] >= 1) v[i] = 1'b1;
      else v[i] = (mE[d] < P_R[d] + i * P_S[d]);
    end
    return v;
  endfunction

  function automatic logic [31:0] expState(input int d);
    if (mCause[d] != 0) return 32'd2;
    if (mE[d] >= lastRel(d)) return 32'd1;
    return 32'd0;
  endfunction

  function automatic logic [31:0] getRo(input int d);
    case (d)
      0:       return {30'b0, rstOut0};
      1:       return {28'b0, rstOut1};
      default: return {29'b0, rstOut2};
    endcase
  endfunction

  function automatic logic [31:0] getCyc(input int d);
    case (d)
      0:       return cyc0;
      1:       return cyc1;
      default: return cyc2;
    endcase
  endfunction

  function automatic logic [31:0] getSt(input int d);
    case (d)
      0:       return {30'b0, st0};
      1:       return {30'b0, st1};
      default: return {30'b0, st2};
    endcase
  endfunction

  function automatic logic [31:0] getCa(input int d);
    case (d)
      0:       return {30'b0, ca0};
      1:       return {30'b0, ca1};
      default: return {30'b0, ca2};
    endcase
  endfunction

  task automatic stepModel(input int d);
    if (rstIn) begin
      mE[d] = 0; mCyc[d] = 0; mIdle[d] = 0; mCause[d] = 0; mAge[d] = 0;
    end else if (mE[d] < lastRel(d)) begin
      mE[d]++;
    end else if (mCause[d] == 0) begin
      mCyc[d]++;
      mIdle[d] = kickIn ? 0 : mIdle[d] + 1;
      if (haltIn) mCause[d] = 1;
      else if (P_IL[d] != 0 && !kickIn && mIdle[d] == P_IL[d]) mCause[d] = 2;
      else if (mCyc[d] == P_TO[d]) mCause[d] = 3;
    end else begin
      mAge[d]++;
    end
  endtask

  // Compare every instance against the model, then advance the model with
  // the inputs that the coming rising edge will sample.
  always @(negedge clk) begin
    if (mValid) begin
      for (int d = 0; d < 3; d++) begin
        checkOutput("rst_out", d, getRo(d), expRstOut(d));
        checkOutput("cycle_cnt", d, getCyc(d), 32'(mCyc[d]));
        checkOutput("state", d, getSt(d), expState(d));
        checkOutput("cause", d, getCa(d), 32'(mCause[d]));
      end
    end
    for (int d = 0; d < 3; d++) stepModel(d);
    if (rstIn) mValid = 1'b1;
  end

  // Directed scenarios with literal expectations, then randomized runs.
  initial begin
    int len;
    int kp;
    logic r, k, h;

    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("reset_rst_out", 0, {30'b0, rstOut0}, 32'h3);
    checkOutput("reset_rst_out", 1, {28'b0, rstOut1}, 32'hF);
    checkOutput("reset_cycle", 0, cyc0, 32'd0);
    checkOutput("reset_state", 0, {30'b0, st0}, 32'd0);
    checkOutput("reset_cause", 0, {30'b0, ca0}, 32'd0);

    // Release with kick every cycle.
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("edge4_rst_out", 0, {30'b0, rstOut0}, 32'h3);
    checkOutput("edge4_rst_out", 1, {28'b0, rstOut1}, 32'hF);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("edge5_rst_out", 0, {30'b0, rstOut0}, 32'h2);
    checkOutput("edge5_rst_out", 1, {28'b0, rstOut1}, 32'h0);
    checkOutput("edge5_state", 1, {30'b0, st1}, 32'd1);
    checkOutput("edge5_state", 0, {30'b0, st0}, 32'd0);
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("edge7_rst_out", 0, {30'b0, rstOut0}, 32'h0);
    checkOutput("edge7_state", 0, {30'b0, st0}, 32'd1);

    // Hang: kick through RUN cycle 10, then silence.
    repeat (10) applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (7) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("prehang_cause", 0, {30'b0, ca0}, 32'd0);
    checkOutput("prehang_cycle", 0, cyc0, 32'd17);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("hang_cause", 0, {30'b0, ca0}, 32'd2);
    checkOutput("hang_cycle", 0, cyc0, 32'd18);
    checkOutput("hang_state", 0, {30'b0, st0}, 32'd2);
    checkOutput("hang_rst_out", 0, {30'b0, rstOut0}, 32'h0);
    checkOutput("timeout_cause", 1, {30'b0, ca1}, 32'd3);
    checkOutput("timeout_cycle", 1, cyc1, 32'd20);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("stop_rst_out", 0, {30'b0, rstOut0}, 32'h3);
    checkOutput("stop_sticky_cause", 0, {30'b0, ca0}, 32'd2);
    checkOutput("stop_hold_cycle", 0, cyc0, 32'd18);

    // Reset pulse while stopped.
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("stoprst_state", 0, {30'b0, st0}, 32'd0);
    checkOutput("stoprst_cause", 0, {30'b0, ca0}, 32'd0);
    checkOutput("stoprst_cycle", 0, cyc0, 32'd0);
    checkOutput("stoprst_rst_out", 0, {30'b0, rstOut0}, 32'h3);

    // Reset pulse mid-RUN.
    repeat (12) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("midrun_cycle", 0, cyc0, 32'd5);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("midrst_state", 0, {30'b0, st0}, 32'd0);
    checkOutput("midrst_cycle", 0, cyc0, 32'd0);
    checkOutput("midrst_rst_out", 1, {28'b0, rstOut1}, 32'hF);

    // No kick at all: hang on dut0, pure timeout on dut1 (hang disabled).
    repeat (15) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("nokick_hang_cause", 0, {30'b0, ca0}, 32'd2);
    checkOutput("nokick_hang_cycle", 0, cyc0, 32'd8);
    repeat (10) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("nokick_to_cause", 1, {30'b0, ca1}, 32'd3);
    checkOutput("nokick_to_cycle", 1, cyc1, 32'd20);

    // halt_req, hang and timeout coincide on dut0 RUN cycle 50.
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (49) applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (7) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("precoinc_cycle", 0, cyc0, 32'd49);
    checkOutput("precoinc_cause", 0, {30'b0, ca0}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("coinc_cause", 0, {30'b0, ca0}, 32'd1);
    checkOutput("coinc_cycle", 0, cyc0, 32'd50);

    // Randomized runs checked by the per-cycle model.
    for (int run = 0; run < 30; run++) begin
      repeat ($urandom_range(1, 2)) applyStimulus(1'b1, 1'(($urandom_range(0, 1))), 1'b0);
      len = $urandom_range(10, 70);
      kp  = $urandom_range(5, 10);
      for (int c = 0; c < len; c++) begin
        r = ($urandom_range(0, 99) == 0);
        k = ($urandom_range(0, 9) < kp);
        h = ($urandom_range(0, 59) == 0);
        applyStimulus(r, k, h);
      end
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nFail);
    $finish;
  end

endmodule

// File: doc/rstseq_wdog.md
# rstseq_wdog

Parametrised reset sequencer and run watchdog for the processor test harness. It takes the single system clock and a master synchronous reset, then releases N_CH downstream reset channels in a staggered order. During the run it counts cycles, detects a global timeout, detects a hang (no heartbeat within an idle window) and latches a normal-completion request. The terminating cause is reported on status outputs and, optionally, ends the simulation.

## Interface
Parameters:
- N_CH, 2: number of downstream reset channels (≥1).
- RESET_CYCLES, 5: low-rst cycles before channel 0 releases (≥1).
- STAGGER, 2: extra cycles between consecutive channel releases (≥0).
- TIMEOUT, 100000: RUN cycles before a timeout stop (≥1).
- IDLE_LIMIT, 1024: RUN cycles without `kick` before a hang stop; 0 disables hang detection.
- CNT_W, 32: width of counters; must satisfy 2^CNT_W > max(TIMEOUT, RESET_CYCLES+(N_CH-1)*STAGGER); elaboration error otherwise.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  master reset. One clock; reset is synchronous and active-high.
- kick  in  1  heartbeat (e.g. instruction retire); sampled only in RUN.
- halt_req  in  1  program-complete request; sampled only in RUN.
- rst_out  out  N_CH  per-channel active-high reset, registered.
- cycle_cnt  out  CNT_W  RUN cycles elapsed.
- state  out  2  0=RESET, 1=RUN, 2=STOP.
- cause  out  2  0=none, 1=done, 2=hang, 3=timeout; sticky until rst.

## Operation
- The FSM has three states: RESET, RUN and STOP. rst=1 at any edge, in any state, forces RESET and clears phase_cnt, idle_cnt, cycle_cnt and cause. It sets rst_out to all ones.
- RESET with rst=0, each edge:
  - phase_cnt <= phase_cnt+1.
  - rst_out[i] <= (phase_cnt+1 < RESET_CYCLES + i*STAGGER).
  - Channels release in ascending index. Channels with equal thresholds release together (STAGGER=0).
- RESET→RUN occurs on the same edge that rst_out[N_CH-1] falls.
- RUN, each edge:
  - cycle_cnt increments.
  - idle_cnt clears on kick, otherwise increments.
  - Stop checks apply in priority order halt_req > hang > timeout:
    - halt_req=1: cause<=1.
    - IDLE_LIMIT≠0 and kick=0 and idle_cnt+1==IDLE_LIMIT: cause<=2.
    - cycle_cnt+1==TIMEOUT: cause<=3.
  - Any of these moves the FSM to STOP on that edge.
- STOP: all rst_out reassert on the next edge to freeze downstream. Counters hold, and cause holds. Only rst exits STOP.
- Counters never wrap, because the CNT_W rule guarantees this.

## Timing
- Reset values: rst_out all 1, cycle_cnt 0, state 0, cause 0.
- With RESET_CYCLES=R and STAGGER=S, rst low from edge 1:
  - rst_out[i] is low after edge R+i*S.
  - state=1 after edge R+(N_CH-1)*S.
- Stop latency: the stopping condition is sampled at edge k. cause and state=2 are visible after edge k. rst_out returns high after edge k+1.
- Deasserting halt_req or kick after a stop has no effect.

## Configuration
- SIM_FINISH_EN defined: on STOP entry the block $displays cause and cycle_cnt, then calls $finish one edge later. It also $fatal's at elaboration on a CNT_W violation.
- SIM_FINISH_EN undefined: no system tasks are used, and the block is synthesizable. It remains in STOP until rst.

## Structure
- Package rstseq_pkg holds:
  - state_e (RESET/RUN/STOP).
  - cause_e (NONE/DONE/HANG/TIMEOUT).
  - A localparam helper for the last-release threshold.
- One sub-module, rstseq_idle_cnt, contains the kick-clearable idle counter with a limit compare and a disable-when-0 option. All other logic lives in the top.

## Test plan
- Defaults, rst high 3 cycles then low, kick every cycle:
  - rst_out[0] falls after edge 5 and rst_out[1] after edge 7.
  - state=1 after edge 7.
  - cause=3 after cycle_cnt reaches 100000.
- TIMEOUT=50, IDLE_LIMIT=8, kick stops at RUN cycle 10: cause=2 at cycle_cnt=18, rst_out=2'b11 the following cycle.
- halt_req, kick=0 and timeout all coincident on the final cycle: cause=1 (done wins).
- IDLE_LIMIT=0, no kick, TIMEOUT=20: no hang, cause=3 at cycle_cnt=20.
- rst pulsed for 1 cycle mid-RUN and again in STOP:
  - state=0, cause=0, cycle_cnt=0 and rst_out all 1 next cycle.
  - Full release sequence repeats.
- N_CH=4, STAGGER=0: all four channels fall together after edge RESET_CYCLES.
